// File: rtl/conv_ctrl_pkg.sv
// Shared types and sizing helpers for the convolution frame controller.
package conv_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Kernel words: COL*COL weights plus one bias
  function automatic int kwords(input int col);
    return col * col + 1;
  endfunction

  // Total kernel bus width
  function automatic int kernel_w(input int bw, input int col);
    return bw * kwords(col);
  endfunction

  // Counter width able to index 0..n-1 (at least one bit)
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_valid_tag.sv
// Fixed-depth 1-bit delay line aligning window tags with core results.
module conv_valid_tag #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr;

  generate
    if (DEPTH == 1) begin : g_single
      // Single-stage delay
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) sr <= '0;
        else       sr <= din;
      end
    end else begin : g_multi
      // Shift the tag one stage per clock
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) sr <= '0;
        else       sr <= {sr[DEPTH-2:0], din};
      end
    end
  endgenerate

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/conv_frame_ctrl.sv
// Kernel loader and frame sequencer for the convolution core.
`ifndef BIT_WIDTH
`define BIT_WIDTH 8
`endif
`ifndef COL
`define COL 3
`endif
`ifndef IN_WIDTH
`define IN_WIDTH 8
`endif
`ifndef OUT_WIDTH
`define OUT_WIDTH 16
`endif

module conv_frame_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter int BIT_WIDTH = `BIT_WIDTH,
  parameter int COL       = `COL,
  parameter int IN_WIDTH  = `IN_WIDTH,
  parameter int OUT_WIDTH = `OUT_WIDTH,
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28,
  parameter int CORE_LAT  = 2
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             cfg_wr_en,
  input  logic [BIT_WIDTH-1:0]             cfg_wr_data,
  input  logic                             start,
  input  logic [IN_WIDTH-1:0]              s_pixel,
  input  logic                             s_valid,
  output logic                             s_ready,
  output logic [BIT_WIDTH*(COL*COL+1)-1:0] conv_kernel,
  output logic [IN_WIDTH-1:0]              conv_pixel,
  output logic                             conv_en,
  input  logic [OUT_WIDTH-1:0]             conv_result,
  output logic [OUT_WIDTH-1:0]             m_result,
  output logic                             m_valid,
  output logic                             busy,
  output logic                             done,
  output logic                             cfg_err,
  output logic [15:0]                      out_cnt
);

  localparam int KWORDS   = kwords(COL);
  localparam int KERNEL_W = kernel_w(BIT_WIDTH, COL);
  localparam int CW       = cnt_w(IMG_W);
  localparam int RW       = cnt_w(IMG_H);
  localparam int IW       = cnt_w(KWORDS);
  localparam int DW       = cnt_w(CORE_LAT + 2);

  state_t          state;
  logic [IW-1:0]   widx;
  logic            kernel_loaded;
  logic [RW-1:0]   row;
  logic [CW-1:0]   col;
  logic [DW-1:0]   drain_cnt;
  logic            tag_d;
  logic            tag_q;

  assign busy = (state != IDLE);

  // Frame FSM: kernel load, pixel acceptance, position tracking, drain
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      widx          <= '0;
      kernel_loaded <= 1'b0;
      row           <= '0;
      col           <= '0;
      drain_cnt     <= '0;
      tag_d         <= 1'b0;
      s_ready       <= 1'b0;
      conv_kernel   <= '0;
      conv_pixel    <= '0;
      conv_en       <= 1'b0;
      done          <= 1'b0;
      cfg_err       <= 1'b0;
      out_cnt       <= '0;
    end else begin
      conv_en <= 1'b0;
      tag_d   <= 1'b0;
      done    <= 1'b0;
      cfg_err <= 1'b0;
      if (m_valid) out_cnt <= out_cnt + 16'd1;

      case (state)
        IDLE: begin
          if (cfg_wr_en) begin
            for (int unsigned k = 0; k < KWORDS; k++) begin
              if (32'(widx) == k)
                conv_kernel[KERNEL_W-1-k*BIT_WIDTH -: BIT_WIDTH] <= cfg_wr_data;
            end
            if (widx == IW'(KWORDS - 1)) begin
              widx          <= '0;
              kernel_loaded <= 1'b1;
            end else begin
              widx          <= widx + IW'(1);
              kernel_loaded <= 1'b0;
            end
          end
          // start sees kernel_loaded as it was before any same-cycle write
          if (start) begin
            if (kernel_loaded) begin
              state   <= RUN;
              row     <= '0;
              col     <= '0;
              out_cnt <= '0;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end

        RUN: begin
          s_ready <= 1'b1;
          if (s_valid && s_ready) begin
            conv_pixel <= s_pixel;
            conv_en    <= 1'b1;
            tag_d      <= (row >= RW'(COL - 1)) && (col >= CW'(COL - 1));
            if (col == CW'(IMG_W - 1)) begin
              col <= '0;
              if (row == RW'(IMG_H - 1)) begin
                state     <= DRAIN;
                s_ready   <= 1'b0;
                drain_cnt <= '0;
              end else begin
                row <= row + RW'(1);
              end
            end else begin
              col <= col + CW'(1);
            end
          end
        end

        DRAIN: begin
          if (drain_cnt == DW'(CORE_LAT + 1)) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
          end
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

  conv_valid_tag #(.DEPTH(CORE_LAT)) u_tag (
    .clk  (clk),
    .rstn (rstn),
    .din  (tag_d),
    .dout (tag_q)
  );

  // Register the core result together with its delayed window tag
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_result <= '0;
      m_valid  <= 1'b0;
    end else begin
      m_result <= conv_result;
      m_valid  <= tag_q;
    end
  end

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Self-checking bench for conv_frame_ctrl with a behavioural scoreboard.
module tb_conv_frame_ctrl;

  localparam int BW   = 8;
  localparam int COLN = 3;
  localparam int INW  = 8;
  localparam int OUTW = 16;
  localparam int W    = 5;
  localparam int H    = 5;
  localparam int LAT  = 2;
  localparam int KW   = BW * (COLN * COLN + 1);
  localparam int NPIX = W * H;
  localparam int NOUT = (H - COLN + 1) * (W - COLN + 1);

  logic            clk = 1'b0;
  logic            rstn;
  logic            cfg_wr_en;
  logic [BW-1:0]   cfg_wr_data;
  logic            start;
  logic [INW-1:0]  s_pixel;
  logic            s_valid;
  logic            s_ready;
  logic [KW-1:0]   conv_kernel;
  logic [INW-1:0]  conv_pixel;
  logic            conv_en;
  logic [OUTW-1:0] conv_result;
  logic [OUTW-1:0] m_result;
  logic            m_valid;
  logic            busy;
  logic            done;
  logic            cfg_err;
  logic [15:0]     out_cnt;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  conv_frame_ctrl #(
    .BIT_WIDTH (BW),
    .COL       (COLN),
    .IN_WIDTH  (INW),
    .OUT_WIDTH (OUTW),
    .IMG_W     (W),
    .IMG_H     (H),
    .CORE_LAT  (LAT)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .cfg_wr_en   (cfg_wr_en),
    .cfg_wr_data (cfg_wr_data),
    .start       (start),
    .s_pixel     (s_pixel),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .conv_kernel (conv_kernel),
    .conv_pixel  (conv_pixel),
    .conv_en     (conv_en),
    .conv_result (conv_result),
    .m_result    (m_result),
    .m_valid     (m_valid),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err),
    .out_cnt     (out_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Core stand-in: pixel + 0x100 after two clocks
  logic [OUTW-1:0] core_p1 = '0;
  logic [OUTW-1:0] core_p2 = '0;
  always @(posedge clk) begin
    core_p1 <= 16'h100 + 16'(conv_pixel);
    core_p2 <= core_p1;
  end
  assign conv_result = core_p2;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    int              due;
    logic [OUTW-1:0] val;
  } exp_t;

  exp_t            q[$];
  bit              pend_en = 1'b0;
  logic [INW-1:0]  pend_pix = '0;
  int              acc_cnt = 0;
  int              mv_cnt = 0;
  int              last_mv = 0;
  int              done_cnt = 0;
  logic [OUTW-1:0] got [NOUT];

  // Each accepted pixel n sits at row n/W, col n%W; full-window pixels must
  // come back as pixel+0x100 exactly 2+LAT cycles after the accept.
  always @(negedge clk) begin
    exp_t e;
    if (!rstn) begin
      q.delete();
      pend_en = 1'b0;
      acc_cnt = 0;
      mv_cnt  = 0;
    end else begin
      chk("conv_en", 128'(conv_en), 128'(pend_en));
      if (pend_en) chk("conv_pixel", 128'(conv_pixel), 128'(pend_pix));
      pend_en  = s_valid && s_ready;
      pend_pix = s_pixel;
      if (pend_en) begin
        if ((acc_cnt / W) >= COLN - 1 && (acc_cnt % W) >= COLN - 1) begin
          e.due = cyc + 2 + LAT;
          e.val = 16'h100 + 16'(s_pixel);
          q.push_back(e);
        end
        acc_cnt++;
      end
      if (m_valid) begin
        if (q.size() == 0) begin
          chk("m_valid_spurious", 128'(m_valid), 128'(0));
        end else begin
          e = q.pop_front();
          chk("m_valid_time", 128'(cyc), 128'(e.due));
          chk("m_result", 128'(m_result), 128'(e.val));
        end
        if (mv_cnt < NOUT) got[mv_cnt] = m_result;
        mv_cnt++;
        last_mv = cyc;
      end else if (q.size() > 0 && q[0].due <= cyc) begin
        chk("m_valid_missing", 128'(m_valid), 128'(1));
        e = q.pop_front();
      end
      if (done) begin
        chk("done_time", 128'(cyc), 128'(last_mv + 1));
        chk("out_cnt_end", 128'(out_cnt), 128'(NOUT));
        chk("mvalid_count", 128'(mv_cnt), 128'(NOUT));
        chk("accept_count", 128'(acc_cnt), 128'(NPIX));
        chk("queue_empty", 128'(q.size()), 128'(0));
        acc_cnt = 0;
        mv_cnt  = 0;
        done_cnt++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic reset_pulse();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  task automatic load(input logic [KW-1:0] k, input int extra);
    for (int i = 0; i < KW / BW; i++) begin
      cfg_wr_en   = 1'b1;
      cfg_wr_data = k[KW-1-BW*i -: BW];
      tick();
    end
    for (int i = 0; i < extra; i++) begin
      cfg_wr_en   = 1'b1;
      cfg_wr_data = 8'hEE;
      tick();
    end
    cfg_wr_en = 1'b0;
  endtask

  // mode 0: valid held high, pixels 0..; mode 1: valid every other cycle;
  // mode 2: random valid and random pixels. junk drives 0xFF config writes.
  task automatic run_frame(input int mode, input bit junk, input logic [KW-1:0] kexp);
    int sent = 0;
    int budget = 0;
    int d0;
    bit acc;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_run", 128'(busy), 128'(1));
    chk("s_ready_first", 128'(s_ready), 128'(0));
    chk("out_cnt_start", 128'(out_cnt), 128'(0));
    while (sent < NPIX && budget < 400) begin
      case (mode)
        0:       s_valid = 1'b1;
        1:       s_valid = (budget % 2) == 1;
        default: s_valid = ($urandom_range(0, 3) != 0);
      endcase
      s_pixel     = (mode == 2) ? 8'($urandom) : 8'(sent);
      cfg_wr_en   = junk;
      cfg_wr_data = 8'hFF;
      acc = s_valid && s_ready;
      tick();
      if (acc) sent++;
      budget++;
    end
    s_valid   = 1'b0;
    cfg_wr_en = 1'b0;
    chk("pixels_sent", 128'(sent), 128'(NPIX));
    chk("s_ready_drop", 128'(s_ready), 128'(0));
    d0 = done_cnt;
    for (int i = 0; i < 30 && done_cnt == d0; i++) @(posedge clk);
    #1;
    chk("done_seen", 128'(done_cnt), 128'(d0 + 1));
    chk("busy_idle", 128'(busy), 128'(0));
    chk("kernel_kept", 128'(conv_kernel), 128'(kexp));
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [KW-1:0] k;
    int            extra;
    logic [KW-1:0] kexp;
    bit            err;
  } vec_t;

  vec_t tbl [4];

  localparam logic [OUTW-1:0] EXPR [NOUT] = '{
    16'h10C, 16'h10D, 16'h10E,
    16'h111, 16'h112, 16'h113,
    16'h116, 16'h117, 16'h118
  };

  localparam logic [KW-1:0] K1 = 80'h0102030405060708090A;

  initial begin
    int n;
    bit acc;
    tbl[0] = '{80'h0102030405060708090A, 0, 80'h0102030405060708090A, 1'b0};
    tbl[1] = '{80'h112233445566778899AA, 3, 80'hEEEEEE445566778899AA, 1'b1};
    tbl[2] = '{80'hFFFFFFFFFFFFFFFFFFFF, 9, 80'hEEEEEEEEEEEEEEEEEEFF, 1'b1};
    tbl[3] = '{80'h00000000000000000000, 0, 80'h00000000000000000000, 1'b0};

    rstn = 1'b0; cfg_wr_en = 1'b0; cfg_wr_data = '0; start = 1'b0;
    s_pixel = '0; s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", 128'(s_ready), 128'(0));
    chk("rst_kernel", 128'(conv_kernel), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_out_cnt", 128'(out_cnt), 128'(0));
    chk("rst_m_valid", 128'(m_valid), 128'(0));
    rstn = 1'b1;
    tick();

    // Kernel load table: full loads, partial rewrites, start outcome
    for (int r = 0; r < 4; r++) begin
      reset_pulse();
      load(tbl[r].k, tbl[r].extra);
      chk("load_busy", 128'(busy), 128'(0));
      chk("load_kernel", 128'(conv_kernel), 128'(tbl[r].kexp));
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("tbl_cfg_err", 128'(cfg_err), 128'(tbl[r].err));
      chk("tbl_busy", 128'(busy), 128'(!tbl[r].err));
      tick();
      chk("tbl_cfg_err_pulse", 128'(cfg_err), 128'(0));
      if (busy) reset_pulse();
    end

    // Start with no kernel after reset
    reset_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("nokern_cfg_err", 128'(cfg_err), 128'(1));
    chk("nokern_busy", 128'(busy), 128'(0));
    chk("nokern_s_ready", 128'(s_ready), 128'(0));
    tick();
    chk("nokern_err_once", 128'(cfg_err), 128'(0));

    // Dense frame, then a sparse frame right after done with junk writes
    load(K1, 0);
    run_frame(0, 1'b0, K1);
    for (int i = 0; i < NOUT; i++) chk("dense_result", 128'(got[i]), 128'(EXPR[i]));
    run_frame(1, 1'b1, K1);
    for (int i = 0; i < NOUT; i++) chk("sparse_result", 128'(got[i]), 128'(EXPR[i]));

    // Randomized frames against the scoreboard
    for (int f = 0; f < 4; f++) begin
      run_frame(2, 1'($urandom_range(0, 1)), K1);
      repeat ($urandom_range(0, 3)) tick();
    end

    // Reset in the middle of a frame
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    for (int i = 0; i < 100 && n < 10; i++) begin
      s_valid = 1'b1;
      s_pixel = 8'(n);
      acc = s_valid && s_ready;
      tick();
      if (acc) n++;
    end
    chk("mid_accepts", 128'(n), 128'(10));
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_s_ready", 128'(s_ready), 128'(0));
    chk("mid_kernel", 128'(conv_kernel), 128'(0));
    chk("mid_conv_pixel", 128'(conv_pixel), 128'(0));
    chk("mid_conv_en", 128'(conv_en), 128'(0));
    chk("mid_m_result", 128'(m_result), 128'(0));
    chk("mid_m_valid", 128'(m_valid), 128'(0));
    chk("mid_busy", 128'(busy), 128'(0));
    chk("mid_done", 128'(done), 128'(0));
    chk("mid_cfg_err", 128'(cfg_err), 128'(0));
    chk("mid_out_cnt", 128'(out_cnt), 128'(0));
    s_valid = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("mid_restart_err", 128'(cfg_err), 128'(1));
    chk("mid_restart_busy", 128'(busy), 128'(0));
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
